hps_capture_cmd_ctrl: RTL

Command engine directly downstream of the HPS-written 32-bit PIO output register. It decodes the PIO word as a toggle-handshaked command, runs ADC sample capture into an external dual-port sample RAM, and serves single-word readback. Results go to a 32-bit response word that feeds an HPS-readable input PIO. Everything sits in the one `clk` domain shared with the PIO.

---
 rtl/hps_capture_cmd_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hps_capture_cmd_ctrl.sv
// hps_capture_cmd_ctrl: toggle-handshaked PIO command engine that captures ADC
// samples into an external dual-port RAM and serves single-word readback.
module hps_capture_cmd_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cmd_word,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       resp_word,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RD_WAIT = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ARM    = 3'd1,
    OP_STOP   = 3'd2,
    OP_READ   = 3'd3,
    OP_STATUS = 3'd4
  } opcode_t;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_ERR_BUSY  = 3'd1,
    ST_ERR_RANGE = 3'd2,
    ST_ERR_OP    = 3'd3
  } status_t;

  localparam logic [ADDR_W:0] FILL_ONE = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic              req_tog, req_tog_nx;
  logic [ADDR_W:0]   fill, fill_nx;
  logic              full, full_nx;
  logic [ADDR_W-1:0] raddr_nx;
  logic [31:0]       resp_nx;

  logic              ack_nx;
  logic [2:0]        status_nx;
  logic [15:0]       data_nx;
  logic              respond;
  status_t           rsp_status;
  logic [15:0]       rsp_data;
  logic              we;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic              pending;
  logic              accept;
  logic              arm;
  logic              capturing;
  logic              unused_cmd;

  assign opcode     = cmd_word[30:28];
  assign addr       = cmd_word[ADDR_W-1:0];
  assign pending    = cmd_word[31] != req_tog;
  assign capturing  = state == CAPTURE;
  assign accept     = pending && (state == IDLE || state == CAPTURE);
  assign arm        = accept && opcode == OP_ARM;
  assign unused_cmd = ^cmd_word[27:ADDR_W];

  assign ram_we    = we;
  assign ram_waddr = fill[ADDR_W-1:0];
  assign ram_wdata = adc_data;
  assign busy      = state != IDLE;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Handshake, fill/full tracking, read address and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_tog   <= 1'b0;
      fill      <= '0;
      full      <= 1'b0;
      ram_raddr <= '0;
      resp_word <= '0;
    end else begin
      req_tog   <= req_tog_nx;
      fill      <= fill_nx;
      full      <= full_nx;
      ram_raddr <= raddr_nx;
      resp_word <= resp_nx;
    end
  end

  // Next-state, capture write, command decode and response composition.
  always_comb begin
    state_nx   = state;
    req_tog_nx = req_tog;
    fill_nx    = fill;
    full_nx    = full;
    raddr_nx   = ram_raddr;
    ack_nx     = resp_word[31];
    status_nx  = resp_word[30:28];
    data_nx    = resp_word[15:0];
    we         = 1'b0;
    respond    = 1'b0;
    rsp_status = ST_OK;
    rsp_data   = '0;

    // A concurrent ARM restarts the buffer, so the coincident sample is dropped.
    if (capturing && adc_valid && !arm) begin
      we      = 1'b1;
      fill_nx = fill + FILL_ONE;
      if (fill_nx[ADDR_W]) begin
        full_nx  = 1'b1;
        state_nx = IDLE;
      end
    end

    if (accept) begin
      req_tog_nx = cmd_word[31];
      respond    = 1'b1;
      case (opcode)
        OP_NOP, OP_STATUS: rsp_data = 16'(fill);
        OP_ARM: begin
          fill_nx  = '0;
          full_nx  = 1'b0;
          state_nx = CAPTURE;
        end
        OP_STOP: begin
          if (capturing) state_nx = IDLE;
        end
        OP_READ: begin
          if (capturing) begin
            rsp_status = ST_ERR_BUSY;
          end else if ({1'b0, addr} >= fill) begin
            rsp_status = ST_ERR_RANGE;
          end else begin
            // Ack is deferred until the RAM data returns in RD_DATA.
            respond  = 1'b0;
            raddr_nx = addr;
            state_nx = RD_WAIT;
          end
        end
        default: rsp_status = ST_ERR_OP;
      endcase
    end

    case (state)
      RD_WAIT: state_nx = RD_DATA;
      RD_DATA: begin
        state_nx = IDLE;
        respond  = 1'b1;
        rsp_data = 16'(ram_rdata);
      end
      default: ;
    endcase

    if (respond) begin
      ack_nx    = req_tog_nx;
      status_nx = rsp_status;
      data_nx   = rsp_data;
    end

    resp_nx = {ack_nx, status_nx, full_nx, state_nx == CAPTURE, 10'd0, data_nx};
  end

endmodule
